// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: motion controller for one sprite character.
// Turns left/right/jump requests and collision flags into x/y, facing,
// state and animation frame, with ramped rise/fall speeds.
// Optional feature: define DOUBLE_JUMP_EN to allow one mid-air jump.
module char_motion_ctrl #(
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 10,
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned SCREEN_W   = 1024,
  parameter int unsigned FLOOR_Y    = 767,
  parameter int unsigned SPAWN_X    = 100,
  parameter int unsigned SPAWN_Y    = 600,
  parameter int unsigned STEP_GND   = 400_000,
  parameter int unsigned STEP_AIR   = 700_000,
  parameter int unsigned JUMP_H     = 200,
  parameter int unsigned EASE_PX    = 25,
  parameter int unsigned RISE_START = 200_000,
  parameter int unsigned RISE_MAX   = 800_000,
  parameter int unsigned FALL_START = 800_000,
  parameter int unsigned FALL_MIN   = 150_000,
  parameter int unsigned RAMP       = 20_000,
  parameter int unsigned ANIM_DIV   = 8,
  parameter int unsigned CNT_W      = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           respawn,
  input  logic           freeze,
  input  logic           left,
  input  logic           right,
  input  logic           jump,
  input  logic           ground_below,
  input  logic           ceiling_hit,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           dir,
  output logic [1:0]     st,
  output logic [2:0]     frame
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WALK = 2'b01,
    FALL = 2'b10,
    RISE = 2'b11
  } state_t;

  localparam logic [X_W-1:0]   X_MAX   = X_W'(SCREEN_W - SPR_W);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(FLOOR_Y - SPR_H);
  localparam logic [X_W-1:0]   X_SPAWN = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0]   Y_SPAWN = Y_W'(SPAWN_Y);
  localparam logic [Y_W-1:0]   JH      = Y_W'(JUMP_H);
  localparam logic [Y_W-1:0]   EZ      = Y_W'(JUMP_H - EASE_PX);
  localparam logic [X_W-1:0]   ADIV    = X_W'(ANIM_DIV);
  localparam logic [CNT_W-1:0] P_GND   = CNT_W'(STEP_GND);
  localparam logic [CNT_W-1:0] P_AIR   = CNT_W'(STEP_AIR);
  localparam logic [CNT_W-1:0] P_RST   = CNT_W'(RISE_START);
  localparam logic [CNT_W-1:0] P_RMAX  = CNT_W'(RISE_MAX);
  localparam logic [CNT_W-1:0] P_FST   = CNT_W'(FALL_START);
  localparam logic [CNT_W-1:0] P_FMIN  = CNT_W'(FALL_MIN);
  localparam logic [CNT_W-1:0] P_RAMP  = CNT_W'(RAMP);
  localparam logic [CNT_W-1:0] P_FTHR  = CNT_W'(FALL_MIN + RAMP);

  state_t           state;
  logic [CNT_W-1:0] xcnt, ycnt, rise_per, fall_per;
  logic [Y_W-1:0]   y0;

  logic             h_pos, h_neg;
  logic [CNT_W-1:0] x_per, xcnt_nx;
  logic [X_W-1:0]   x_nx;
  logic [2:0]       frame_nx;
  logic             x_step;
  logic [Y_W-1:0]   apex, ease_thr;
  logic             rise_exit, fall_land, dj_fire;
  logic [CNT_W:0]   rise_sum;
  logic [CNT_W-1:0] rise_ramped, fall_ramped;

  assign st = state;

  // Horizontal stepping: period counter, clamped move and frame advance
  always_comb begin
    h_pos    = right & ~left;
    h_neg    = left & ~right;
    x_per    = (state == WALK) ? P_GND : P_AIR;
    x_nx     = x;
    frame_nx = frame;
    xcnt_nx  = '0;
    x_step   = 1'b0;
    if ((state != IDLE) && (h_pos || h_neg)) begin
      if (xcnt >= x_per) begin
        if (h_pos && (x < X_MAX)) begin
          x_nx   = x + X_W'(1);
          x_step = 1'b1;
        end else if (h_neg && (x != '0)) begin
          x_nx   = x - X_W'(1);
          x_step = 1'b1;
        end
        if (x_step && ((x_nx % ADIV) == '0)) frame_nx = frame + 3'd1;
      end else begin
        xcnt_nx = xcnt + CNT_W'(1);
      end
    end
  end

  // Vertical thresholds, exit/landing conditions and saturating ramps
  always_comb begin
    apex        = (y0 > JH) ? (y0 - JH) : '0;
    ease_thr    = (y0 > EZ) ? (y0 - EZ) : '0;
    rise_exit   = (y <= apex) || ceiling_hit || (y == '0);
    fall_land   = ground_below || (y >= Y_MAX);
    rise_sum    = {1'b0, rise_per} + {1'b0, P_RAMP};
    rise_ramped = (rise_sum >= {1'b0, P_RMAX}) ? P_RMAX : rise_sum[CNT_W-1:0];
    fall_ramped = (fall_per >= P_FTHR) ? (fall_per - P_RAMP) : P_FMIN;
  end

`ifdef DOUBLE_JUMP_EN
  logic jump_q, dj_armed;

  // Mid-air jump fires on a jump edge while the token is armed; landing wins
  assign dj_fire = jump & ~jump_q & dj_armed &
                   ((state == RISE) | ((state == FALL) & ~fall_land));

  // Jump edge detector and extra-jump token, re-armed while on the ground
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_q   <= 1'b0;
      dj_armed <= 1'b1;
    end else if (respawn) begin
      jump_q   <= jump;
      dj_armed <= 1'b1;
    end else if (!freeze) begin
      jump_q <= jump;
      if (dj_fire) dj_armed <= 1'b0;
      else if ((state == IDLE) || (state == WALK)) dj_armed <= 1'b1;
    end
  end
`else
  assign dj_fire = 1'b0;
`endif

  // Main FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= X_SPAWN;
      y        <= Y_SPAWN;
      dir      <= 1'b1;
      state    <= IDLE;
      frame    <= '0;
      xcnt     <= '0;
      ycnt     <= '0;
      rise_per <= P_RST;
      fall_per <= P_FST;
      y0       <= '0;
    end else if (respawn) begin
      x        <= X_SPAWN;
      y        <= Y_SPAWN;
      state    <= IDLE;
      frame    <= '0;
      xcnt     <= '0;
      ycnt     <= '0;
      rise_per <= P_RST;
      fall_per <= P_FST;
    end else if (!freeze) begin
      if (h_pos) dir <= 1'b1;
      else if (h_neg) dir <= 1'b0;
      x     <= x_nx;
      frame <= frame_nx;
      xcnt  <= xcnt_nx;
      unique case (state)
        IDLE: begin
          ycnt <= '0;
          if (jump) begin
            state    <= RISE;
            y0       <= y;
            rise_per <= P_RST;
          end else if (h_pos || h_neg) begin
            state <= WALK;
          end
        end
        WALK: begin
          ycnt <= '0;
          if (jump) begin
            state    <= RISE;
            y0       <= y;
            rise_per <= P_RST;
          end else if (!(h_pos || h_neg)) begin
            state <= IDLE;
            frame <= '0;
          end else if (!ground_below && (y < Y_MAX)) begin
            state    <= FALL;
            fall_per <= P_FST;
          end
        end
        RISE: begin
          if (dj_fire) begin
            y0       <= y;
            rise_per <= P_RST;
            ycnt     <= '0;
          end else if (rise_exit) begin
            state    <= FALL;
            ycnt     <= '0;
            fall_per <= P_FST;
          end else if (ycnt >= rise_per) begin
            y    <= y - Y_W'(1);
            ycnt <= '0;
            if ((y - Y_W'(1)) <= ease_thr) rise_per <= rise_ramped;
          end else begin
            ycnt <= ycnt + CNT_W'(1);
          end
        end
        FALL: begin
          if (fall_land) begin
            state    <= IDLE;
            frame    <= '0;
            ycnt     <= '0;
            rise_per <= P_RST;
            fall_per <= P_FST;
          end else if (dj_fire) begin
            state    <= RISE;
            y0       <= y;
            rise_per <= P_RST;
            ycnt     <= '0;
          end else if (ycnt >= fall_per) begin
            ycnt     <= '0;
            if (y < Y_MAX) y <= y + Y_W'(1);
            fall_per <= fall_ramped;
          end else begin
            ycnt <= ycnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Bench for char_motion_ctrl: behavioural model compared every cycle plus
// directed scenarios with hand-computed expectations.
module tb_char_motion_ctrl;

  localparam int SX = 100, SY = 600, XMAX = 992, YMAX = 735;
  localparam int SG = 4, SA = 6, JH = 10, EZ = 3;
  localparam int RS = 2, RMAX = 8, FS = 8, FMIN = 2, RAMP = 2, ADIV = 8;
  localparam int ST_IDLE = 0, ST_WALK = 1, ST_FALL = 2, ST_RISE = 3;

  logic       clk = 1'b0;
  logic       rst, respawn, freeze, left, right, jump, ceil_v;
  logic       gnd_en;
  int         gnd_y;
  logic       ground_below, ceiling_hit;
  logic [9:0] x, y;
  logic       dir;
  logic [1:0] st;
  logic [2:0] frame;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Collision unit stand-in: a single platform line at gnd_y
  assign ground_below = gnd_en && (int'(y) == gnd_y);
  assign ceiling_hit  = ceil_v;

  always #5 clk = ~clk;

  char_motion_ctrl #(
    .X_W(10), .Y_W(10), .SPR_W(32), .SPR_H(32), .SCREEN_W(1024), .FLOOR_Y(767),
    .SPAWN_X(100), .SPAWN_Y(600), .STEP_GND(4), .STEP_AIR(6), .JUMP_H(10),
    .EASE_PX(3), .RISE_START(2), .RISE_MAX(8), .FALL_START(8), .FALL_MIN(2),
    .RAMP(2), .ANIM_DIV(8), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .respawn(respawn), .freeze(freeze),
    .left(left), .right(right), .jump(jump),
    .ground_below(ground_below), .ceiling_hit(ceiling_hit),
    .x(x), .y(y), .dir(dir), .st(st), .frame(frame)
  );

  typedef struct {
    int x, y, dir, st, frame;
    int xc, yc, rp, fp, y0;
    int token, jq;
  } ms_t;

  ms_t m;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  // One clock of character behaviour, written from the movement rules
  function automatic ms_t mstep(ms_t s, bit i_rst, bit i_resp, bit i_frz, bit i_l,
                                bit i_r, bit i_j, bit i_gen, int i_gy, bit i_ceil);
    ms_t n;
    int  h, per, tgt, apex, ease;
    bit  gnd, land, dj;
    n = s;
    if (i_rst) begin
      n.x = SX; n.y = SY; n.dir = 1; n.st = ST_IDLE; n.frame = 0;
      n.xc = 0; n.yc = 0; n.rp = RS; n.fp = FS; n.y0 = 0; n.token = 1; n.jq = 0;
      return n;
    end
    if (i_resp) begin
      n.x = SX; n.y = SY; n.st = ST_IDLE; n.frame = 0;
      n.xc = 0; n.yc = 0; n.rp = RS; n.fp = FS; n.token = 1; n.jq = i_j;
      return n;
    end
    if (i_frz) return s;
    gnd = i_gen && (s.y == i_gy);
    h = (i_r && !i_l) ? 1 : ((i_l && !i_r) ? -1 : 0);
    if (h > 0) n.dir = 1;
    if (h < 0) n.dir = 0;
    if (s.st == ST_IDLE || h == 0) n.xc = 0;
    else begin
      per = (s.st == ST_WALK) ? SG : SA;
      if (s.xc >= per) begin
        n.xc = 0;
        tgt = s.x + h;
        if (tgt >= 0 && tgt <= XMAX) begin
          n.x = tgt;
          if (tgt % ADIV == 0) n.frame = (s.frame + 1) % 8;
        end
      end else n.xc = s.xc + 1;
    end
    apex = imax(s.y0 - JH, 0);
    ease = imax(s.y0 - (JH - EZ), 0);
    land = gnd || (s.y == YMAX);
`ifdef DOUBLE_JUMP_EN
    dj = (s.token != 0) && i_j && (s.jq == 0) &&
         (s.st == ST_RISE || (s.st == ST_FALL && !land));
`else
    dj = 1'b0;
`endif
    n.jq = i_j;
    if (s.st == ST_IDLE || s.st == ST_WALK) n.token = 1;
    if (dj) n.token = 0;
    case (s.st)
      ST_IDLE: begin
        n.yc = 0;
        if (i_j) begin n.st = ST_RISE; n.y0 = s.y; n.rp = RS; end
        else if (h != 0) n.st = ST_WALK;
      end
      ST_WALK: begin
        n.yc = 0;
        if (i_j) begin n.st = ST_RISE; n.y0 = s.y; n.rp = RS; end
        else if (h == 0) begin n.st = ST_IDLE; n.frame = 0; end
        else if (!gnd && s.y < YMAX) begin n.st = ST_FALL; n.fp = FS; end
      end
      ST_RISE: begin
        if (dj) begin n.y0 = s.y; n.rp = RS; n.yc = 0; end
        else if (s.y <= apex || i_ceil || s.y == 0) begin
          n.st = ST_FALL; n.yc = 0; n.fp = FS;
        end else if (s.yc >= s.rp) begin
          n.y = s.y - 1; n.yc = 0;
          if (n.y <= ease) n.rp = imin(s.rp + RAMP, RMAX);
        end else n.yc = s.yc + 1;
      end
      default: begin
        if (land) begin
          n.st = ST_IDLE; n.frame = 0; n.yc = 0; n.rp = RS; n.fp = FS;
        end else if (dj) begin
          n.st = ST_RISE; n.y0 = s.y; n.rp = RS; n.yc = 0;
        end else if (s.yc >= s.fp) begin
          n.yc = 0; n.y = imin(s.y + 1, YMAX); n.fp = imax(s.fp - RAMP, FMIN);
        end else n.yc = s.yc + 1;
      end
    endcase
    return n;
  endfunction

  // Model advances on the same edge as the DUT
  always @(posedge clk)
    m <= mstep(m, rst, respawn, freeze, left, right, jump, gnd_en, gnd_y, ceil_v);

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (int'(x) != m.x || int'(y) != m.y || int'(dir) != m.dir ||
          int'(st) != m.st || int'(frame) != m.frame) begin
        errors++;
        $display("FAIL model t=%0t actual x=%0d y=%0d dir=%0d st=%0d frame=%0d required x=%0d y=%0d dir=%0d st=%0d frame=%0d",
                 $time, x, y, dir, st, frame, m.x, m.y, m.dir, m.st, m.frame);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cnt;
  int fy;

  initial begin
    rst = 1'b1; respawn = 1'b0; freeze = 1'b0; left = 1'b0; right = 1'b0;
    jump = 1'b0; ceil_v = 1'b0; gnd_en = 1'b1; gnd_y = 600;
    tick(3);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_x", int'(x), 100);
    chk("reset_y", int'(y), 600);
    chk("reset_st", int'(st), 0);
    chk("reset_dir", int'(dir), 1);
    chk("reset_frame", int'(frame), 0);

    // walk right: WALK after 1 clk, first px after 6, then every 5
    right = 1'b1;
    tick(1); chk("walk_st", int'(st), 1);
    tick(4); chk("walk_x5", int'(x), 100);
    tick(1); chk("walk_x6", int'(x), 101);
    tick(5); chk("walk_x11", int'(x), 102);

    // both directions: back to IDLE, x static
    left = 1'b1;
    tick(1); chk("both_st", int'(st), 0);
    tick(3); chk("both_x", int'(x), 102);

    // walk left into the screen edge; 13 multiples of 8 crossed -> frame 5
    right = 1'b0;
    cnt = 0;
    while (x != 0 && cnt < 1000) begin tick(1); cnt++; end
    tick(20);
    chk("left_clamp_x", int'(x), 0);
    chk("left_clamp_frame", int'(frame), 5);
    chk("left_dir", int'(dir), 0);
    left = 1'b0;
    tick(1);
    chk("stop_st", int'(st), 0);
    chk("stop_frame", int'(frame), 0);

    // full jump: apex 590, land back on the platform at 600
    jump = 1'b1; tick(1); jump = 1'b0;
    chk("jump_st", int'(st), 3);
    cnt = 0;
    while (st != 2'b10 && cnt < 300) begin tick(1); cnt++; end
    chk("jump_apex_y", int'(y), 590);
    cnt = 0;
    while (st != 2'b00 && cnt < 500) begin tick(1); cnt++; end
    chk("jump_land_st", int'(st), 0);
    chk("jump_land_y", int'(y), 600);

    // ceiling bump at 595: FALL next clk, first drop 9 clk later
    jump = 1'b1; tick(1); jump = 1'b0;
    cnt = 0;
    while (y != 10'd595 && cnt < 100) begin tick(1); cnt++; end
    ceil_v = 1'b1; tick(1); ceil_v = 1'b0;
    chk("ceil_st", int'(st), 2);
    chk("ceil_y", int'(y), 595);
    cnt = 0;
    while (y == 10'd595 && cnt < 50) begin tick(1); cnt++; end
    chk("ceil_fall_delay", cnt, 9);
    cnt = 0;
    while (st != 2'b00 && cnt < 500) begin tick(1); cnt++; end
    chk("ceil_land_y", int'(y), 600);

    // walk off the platform edge, freeze mid-fall, then respawn
    right = 1'b1;
    tick(10); chk("edge_walk_st", int'(st), 1);
    gnd_en = 1'b0;
    tick(1); chk("edge_fall_st", int'(st), 2);
    tick(12);
    freeze = 1'b1; fy = m.y;
    tick(5); chk("freeze_y", int'(y), fy);
    freeze = 1'b0;
    tick(5);
    respawn = 1'b1; tick(1); respawn = 1'b0;
    chk("respawn_x", int'(x), 100);
    chk("respawn_y", int'(y), 600);
    chk("respawn_st", int'(st), 0);
    chk("respawn_dir", int'(dir), 1);

    // no platform: fall all the way to the floor line
    cnt = 0;
    while (st != 2'b10 && cnt < 20) begin tick(1); cnt++; end
    chk("floor_fall_st", int'(st), 2);
    cnt = 0;
    while (st != 2'b00 && cnt < 3000) begin tick(1); cnt++; end
    chk("floor_y", int'(y), 735);

    // walk into the right screen edge
    cnt = 0;
    while (x != 10'd992 && cnt < 6000) begin tick(1); cnt++; end
    tick(20);
    chk("right_clamp_x", int'(x), 992);
    right = 1'b0;
    tick(2);

`ifdef DOUBLE_JUMP_EN
    // extra jump from FALL relatches y0; a further edge is ignored
    respawn = 1'b1; gnd_en = 1'b1; tick(1); respawn = 1'b0;
    jump = 1'b1; tick(1); jump = 1'b0;
    cnt = 0;
    while (st != 2'b10 && cnt < 300) begin tick(1); cnt++; end
    tick(1);
    jump = 1'b1; tick(1); jump = 1'b0;
    chk("dj_st", int'(st), 3);
    cnt = 0;
    while (st != 2'b10 && cnt < 300) begin tick(1); cnt++; end
    chk("dj_apex_y", int'(y), 580);
    tick(1);
    jump = 1'b1; tick(1); jump = 1'b0;
    chk("dj_third_ignored", int'(st), 2);
    cnt = 0;
    while (st != 2'b00 && cnt < 600) begin tick(1); cnt++; end
    chk("dj_land_y", int'(y), 600);
`endif

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
